// File: rtl/gray_pkg.sv
// Shared definitions for the serial Gray-code decoder: FSM state encoding
// and the default code word width.
package gray_pkg;

  localparam int GRAY_WIDTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } gray_state_t;

endpackage : gray_pkg

// File: rtl/gray_step_check.sv
// Combinational Hamming-distance-one test between two Gray words.
// one_bit is high only when prev and cur differ in exactly one bit position.
module gray_step_check #(
  parameter int WIDTH = gray_pkg::GRAY_WIDTH
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] cur,
  output logic             one_bit
);

  logic [WIDTH-1:0] diff;

  // A non-zero value is a power of two exactly when clearing its lowest set
  // bit leaves nothing behind.
  assign diff    = prev ^ cur;
  assign one_bit = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);

endmodule : gray_step_check

// File: rtl/gray_serial_decoder.sv
// Serial MSB-first Gray-to-binary decoder with running-XOR decode and a
// single-bit-step check against the previously received word.
module gray_serial_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH = GRAY_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             gin,
  output logic [WIDTH-1:0] bin,
  output logic             valid,
  output logic             busy,
  output logic             step_err
);

  localparam int CW = $clog2(WIDTH);

  gray_state_t      state;
  logic [CW-1:0]    cnt;
  logic             run_b;
  logic [WIDTH-2:0] g_sh;
  logic [WIDTH-2:0] b_sh;
  logic [WIDTH-1:0] prev_g;
  logic             has_prev;

  logic             b_bit;
  logic [WIDTH-1:0] g_next;
  logic [WIDTH-1:0] b_next;
  logic             one_bit;

  // The MSB passes straight through; every lower bit folds in the running bit.
  assign b_bit  = gin ^ ((state == ST_SHIFT) ? run_b : 1'b0);
  assign g_next = {g_sh, gin};
  assign b_next = {b_sh, b_bit};

  gray_step_check #(
    .WIDTH (WIDTH)
  ) u_step_check (
    .prev    (prev_g),
    .cur     (g_next),
    .one_bit (one_bit)
  );

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // the pre-edge values; the shift registers are reset too, which keeps
  // simulation X-free even though their contents are overwritten per word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      run_b    <= 1'b0;
      g_sh     <= '0;
      b_sh     <= '0;
      prev_g   <= '0;
      has_prev <= 1'b0;
      bin      <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      step_err <= 1'b0;
    end else begin
      valid    <= 1'b0;
      step_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_SHIFT;
            busy  <= 1'b1;
            cnt   <= CW'(WIDTH - 1);
            run_b <= b_bit;
            g_sh  <= g_next[WIDTH-2:0];
            b_sh  <= b_next[WIDTH-2:0];
          end
        end
        ST_SHIFT: begin
          cnt   <= cnt - CW'(1);
          run_b <= b_bit;
          g_sh  <= g_next[WIDTH-2:0];
          b_sh  <= b_next[WIDTH-2:0];
          // Last bit: publish the whole word at once and remember it.
          if (cnt == CW'(1)) begin
            state    <= ST_IDLE;
            busy     <= 1'b0;
            valid    <= 1'b1;
            bin      <= b_next;
            step_err <= has_prev & ~one_bit;
            prev_g   <= g_next;
            has_prev <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : gray_serial_decoder

// File: doc/gray_serial_decoder.md
GRAY_SERIAL_DECODER -- requirements
Module: gray_serial_decoder

Interface
REQ-001 Parameter WIDTH, default 4, is the code word width in bits; legal range 2..8.
REQ-002 clk  input  1  rising-edge clock; the block has one clock only.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  marks the cycle in which the MSB of a new Gray word is on gin.
REQ-005 gin  input  1  serial Gray code bit, MSB first, one bit per clk.
REQ-006 bin  output  WIDTH  decoded binary word, registered, held until the next valid.
REQ-007 valid  output  1  single-cycle pulse; bin and step_err are meaningful while it is high.
REQ-008 busy  output  1  high while a word is being shifted in (bits 2..WIDTH pending).
REQ-009 step_err  output  1  high with valid when the word is not a single-bit Gray step from the previous word.

Function
REQ-010 The FSM SHALL have two states: IDLE and SHIFT.
REQ-011 IDLE with start=1 SHALL sample gin as g[WIDTH-1], load a bit counter with WIDTH-1, and go to SHIFT.
REQ-012 In SHIFT, each cycle SHALL sample gin as the next lower Gray bit and decrement the counter, ignoring start.
REQ-013 Decode SHALL be running-XOR: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i]; one running bit register, no parallel XOR tree over a stored word.
REQ-014 After g[0] is sampled, the FSM SHALL return to IDLE and, in the next cycle, pulse valid for 1 cycle with the complete bin.
REQ-015 Latency: valid SHALL rise exactly WIDTH cycles after the start cycle (WIDTH=4: start at cycle 0, valid at cycle 4).
REQ-016 busy SHALL be 1 exactly while the FSM is in SHIFT.
REQ-017 start may be asserted in the cycle valid is high; this back-to-back start SHALL be accepted with no gap cycle.
REQ-018 start asserted while in SHIFT SHALL have no effect.
REQ-019 bin SHALL update only on the valid cycle; partial words SHALL never appear on bin.
REQ-020 The block SHALL store the last received Gray word and a has_prev flag.
REQ-021 step_err SHALL be popcount(prev XOR cur) != 1 when has_prev=1, and 0 for the first word after reset.
REQ-022 A repeated identical word (distance 0) SHALL raise step_err.
REQ-023 Wrap-around g=100..0 to 000..0 is distance 1 and SHALL NOT raise step_err.
REQ-024 step_err SHALL be 0 whenever valid is 0.

Reset
REQ-025 rst=1 SHALL force IDLE, bit counter 0, bin=0, valid=0, busy=0, step_err=0, prev word 0, has_prev=0, asynchronously.
REQ-026 Reset mid-word SHALL discard the partial word; no valid SHALL follow it.
REQ-027 After rst falls, the first start on a rising clk edge SHALL be honoured.

Structure
REQ-028 The state enum (IDLE, SHIFT) and the default WIDTH constant SHALL live in a shared package, gray_pkg.
REQ-029 The distance check SHALL be one sub-module, gray_step_check (inputs prev, cur; output one_bit), purely combinational.
REQ-030 All outputs SHALL be driven directly from flops.

Verification
REQ-031 After reset, start with serial 0,0,0,0 -> valid at cycle 4, bin=0000, step_err=0, busy high for cycles 1-3.
REQ-032 Serial 0110 then 0111 back-to-back -> bin=0100 then 0101, step_err 0 then 0, valid 4 cycles apart.
REQ-033 Full Gray sweep 0000..1000 then 0000 -> bin=0..15 then 0, step_err never set.
REQ-034 Serial 0001 then 0010 (distance 2) -> second valid has bin=0011, step_err=1; repeating 0010 -> step_err=1.
REQ-035 rst pulse after 2 bits of 1100 -> no valid; next word 1100 -> bin=1000, step_err=0 because has_prev=0.
REQ-036 start pulsed in every SHIFT cycle of 1011 -> only one word decoded, bin=1101.
